// File: rtl/pio_ctrl_bank_pkg.sv
// Shared constants for the PIO control bank: register addresses and edge capture modes.
package pio_ctrl_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IN       = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_ctrl_bank_if.sv
// Avalon-MM slave register bus for the PIO control bank.
interface pio_ctrl_bank_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/pio_ctrl_bank_sync_edge.sv
// Input synchroniser, previous-value register and combinational edge detect.
module pio_sync_edge
  import pio_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE == EDGE_FALL) begin : g_fall
      assign edge_det = ~in_sync & in_prev;
    end else if (EDGE_MODE == EDGE_ANY) begin : g_any
      assign edge_det = in_sync ^ in_prev;
    end else begin : g_rise
      assign edge_det = in_sync & ~in_prev;
    end
  endgenerate

endmodule

// File: rtl/pio_ctrl_bank.sv
// PIO bank: output register with set/clear, synchronised input with edge capture and irq.
// Optional output watchdog enabled by defining PIO_CTRL_BANK_WDOG_EN.
module pio_ctrl_bank
  import pio_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_MODE   = EDGE_RISE,
  parameter int               WDOG_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_ctrl_bank_if.slave   bus,
  output logic [WIDTH-1:0] out_port,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic             wr;
  logic             wr_data;
  logic             wr_set;
  logic             wr_clr;
  logic             wdog_expire;
  logic             wdog_trip;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_det (edge_det)
  );

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_data = wr & (bus.address == ADDR_DATA);
  assign wr_set  = wr & (bus.address == ADDR_OUTSET);
  assign wr_clr  = wr & (bus.address == ADDR_OUTCLR);
  assign cap_clr = (wr && bus.address == ADDR_EDGE_CAP) ? bus.writedata : '0;

`ifdef PIO_CTRL_BANK_WDOG_EN
  localparam int             CW       = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0]  WDOG_MAX = CW'(WDOG_CYCLES);

  logic [CW-1:0] wdog_cnt;
  logic          wr_out;

  assign wr_out      = wr_data | wr_set | wr_clr;
  assign wdog_expire = ~wr_out & (wdog_cnt == WDOG_MAX - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else begin
      if (wr_out)                    wdog_cnt <= '0;
      else if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_expire)  wdog_trip <= 1'b1;
      else if (wr_data) wdog_trip <= 1'b0;
    end
  end
`else
  // Without the watchdog the timeout parameter has no effect and nothing ever expires.
  assign wdog_expire = 1'(WDOG_CYCLES < 0);
  assign wdog_trip   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VAL;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_data)          data_out <= bus.writedata;
      else if (wr_set)      data_out <= data_out | bus.writedata;
      else if (wr_clr)      data_out <= data_out & ~bus.writedata;
      else if (wdog_expire) data_out <= RESET_VAL;
      if (wr && bus.address == ADDR_IRQ_MASK) irq_mask <= bus.writedata;
      // A fresh edge outranks a simultaneous write-1-clear of the same bit.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:     bus.readdata = data_out;
      ADDR_IN:       bus.readdata = in_sync;
      ADDR_IRQ_MASK: bus.readdata = irq_mask;
      ADDR_EDGE_CAP: bus.readdata = edge_cap;
      ADDR_STATUS:   bus.readdata[0] = wdog_trip;
      default:       bus.readdata = '0;
    endcase
  end

  assign out_port = data_out;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_ctrl_bank.sv
// Scoreboard bench for pio_ctrl_bank: rising-edge bank and any-edge bank, WIDTH=5, RESET_VAL=0x10.
module tb_pio_ctrl_bank;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] out0, out2, in0, in2;
  logic         irq0, irq2;
  int           total = 0;
  int           bad = 0;
  logic [31:0]  exp_q[$];
  logic [W-1:0] rv;

  always #5 clk = ~clk;

  pio_ctrl_bank_if #(.WIDTH(W)) bus0 ();
  pio_ctrl_bank_if #(.WIDTH(W)) bus2 ();

  pio_ctrl_bank #(.WIDTH(W), .RESET_VAL(5'h10), .SYNC_STAGES(2), .EDGE_MODE(0),
                  .WDOG_CYCLES(100)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .out_port(out0), .in_port(in0), .irq(irq0));

  pio_ctrl_bank #(.WIDTH(W), .RESET_VAL(5'h10), .SYNC_STAGES(2), .EDGE_MODE(2),
                  .WDOG_CYCLES(100)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .out_port(out2), .in_port(in2), .irq(irq2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sb_pop();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  task automatic idle(input int s);
    if (s == 0) begin bus0.chipselect = 1'b0; bus0.write_n = 1'b1; end
    else        begin bus2.chipselect = 1'b0; bus2.write_n = 1'b1; end
  endtask

  task automatic wr(input int s, input logic [2:0] a, input logic [W-1:0] d);
    if (s == 0) begin
      bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
    end else begin
      bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
    end
    @(negedge clk);
    idle(s);
  endtask

  task automatic rd(input int s, input logic [2:0] a, output logic [W-1:0] d);
    if (s == 0) begin bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1; end
    else        begin bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b1; end
    #1;
    d = (s == 0) ? bus0.readdata : bus2.readdata;
    idle(s);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    in0 = '0; in2 = '0;
    bus0.address = '0; bus0.writedata = '0; idle(0);
    bus2.address = '0; bus2.writedata = '0; idle(2);
    ticks(3);
    reset_n = 1'b1;
    ticks(1);

    // reset state
    exp_q.push_back(32'h10); chk("rst_out", 32'(out0), sb_pop());
    exp_q.push_back(32'h10); rd(0, 3'd0, rv); chk("rst_data", 32'(rv), sb_pop());
    exp_q.push_back(32'h00); rd(0, 3'd3, rv); chk("rst_cap", 32'(rv), sb_pop());
    exp_q.push_back(32'h0);  chk("rst_irq", 32'(irq0), sb_pop());
    exp_q.push_back(32'h0);  rd(0, 3'd6, rv); chk("rst_status", 32'(rv), sb_pop());

    // output register: load, set, clear
    bus0.address = 3'd0; bus0.writedata = 5'h05; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
    exp_q.push_back(32'h10); #1 chk("data_pre_edge", 32'(out0), sb_pop());
    @(negedge clk); idle(0);
    exp_q.push_back(32'h05); chk("data_wr", 32'(out0), sb_pop());
    exp_q.push_back(32'h17); wr(0, 3'd4, 5'h12); chk("outset", 32'(out0), sb_pop());
    exp_q.push_back(32'h13); wr(0, 3'd5, 5'h04); chk("outclr", 32'(out0), sb_pop());
    exp_q.push_back(32'h13); rd(0, 3'd0, rv); chk("data_rd", 32'(rv), sb_pop());
    exp_q.push_back(32'h00); rd(0, 3'd4, rv); chk("outset_rd", 32'(rv), sb_pop());
    exp_q.push_back(32'h00); rd(0, 3'd5, rv); chk("outclr_rd", 32'(rv), sb_pop());
    exp_q.push_back(32'h13); wr(0, 3'd1, 5'h1f); rd(0, 3'd0, rv); chk("in_wr_ignored", 32'(rv), sb_pop());
    exp_q.push_back(32'h00); wr(0, 3'd7, 5'h1f); rd(0, 3'd7, rv); chk("rsvd_rd", 32'(rv), sb_pop());

    // rising edge on bit2: IN after 2 edges, capture after 3
    in0 = 5'h04;
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h00);
    exp_q.push_back(32'h04); exp_q.push_back(32'h0);
    ticks(1); rd(0, 3'd1, rv); chk("in_lat1", 32'(rv), sb_pop());
    ticks(1); rd(0, 3'd1, rv); chk("in_lat2", 32'(rv), sb_pop());
    rd(0, 3'd3, rv); chk("cap_lat2", 32'(rv), sb_pop());
    ticks(1); rd(0, 3'd3, rv); chk("cap_lat3", 32'(rv), sb_pop());
    chk("irq_masked", 32'(irq0), sb_pop());
    exp_q.push_back(32'h1); wr(0, 3'd2, 5'h04); chk("irq_unmask", 32'(irq0), sb_pop());
    exp_q.push_back(32'h04); rd(0, 3'd2, rv); chk("mask_rd", 32'(rv), sb_pop());
    exp_q.push_back(32'h0); wr(0, 3'd3, 5'h04); chk("irq_clr", 32'(irq0), sb_pop());
    exp_q.push_back(32'h00); rd(0, 3'd3, rv); chk("cap_clr", 32'(rv), sb_pop());

    // falling edge is not captured in rising mode
    in0 = 5'h00;
    exp_q.push_back(32'h00); ticks(4); rd(0, 3'd3, rv); chk("fall_ignored", 32'(rv), sb_pop());

    // capture beats write-1-clear on the same edge; other bits still clear
    in0 = 5'h01; ticks(4);
    exp_q.push_back(32'h01); rd(0, 3'd3, rv); chk("cap_bit0", 32'(rv), sb_pop());
    in0 = 5'h05;
    exp_q.push_back(32'h04); exp_q.push_back(32'h1);
    ticks(2); wr(0, 3'd3, 5'h05);
    rd(0, 3'd3, rv); chk("cap_wins", 32'(rv), sb_pop());
    chk("irq_held", 32'(irq0), sb_pop());

    // asynchronous reset mid-operation
    #2 reset_n = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h10);
    #1 chk("rst_async_irq", 32'(irq0), sb_pop());
    chk("rst_async_out", 32'(out0), sb_pop());
    @(negedge clk); reset_n = 1'b1;

    // input held high through reset is seen as a rising edge
    exp_q.push_back(32'h00); ticks(2); rd(0, 3'd3, rv); chk("held_cap2", 32'(rv), sb_pop());
    exp_q.push_back(32'h05); ticks(1); rd(0, 3'd3, rv); chk("held_cap3", 32'(rv), sb_pop());
    exp_q.push_back(32'h0);  chk("held_irq_mask0", 32'(irq0), sb_pop());
    exp_q.push_back(32'h1);  wr(0, 3'd2, 5'h01); chk("held_irq", 32'(irq0), sb_pop());
    exp_q.push_back(32'h0);  wr(0, 3'd2, 5'h00); chk("irq_mask_off", 32'(irq0), sb_pop());
    wr(0, 3'd3, 5'h1f);

    // any-edge mode: rise, clear, fall
    in2 = 5'h01;
    exp_q.push_back(32'h00); ticks(2); rd(2, 3'd3, rv); chk("any_rise2", 32'(rv), sb_pop());
    exp_q.push_back(32'h01); ticks(1); rd(2, 3'd3, rv); chk("any_rise3", 32'(rv), sb_pop());
    exp_q.push_back(32'h00); wr(2, 3'd3, 5'h01); rd(2, 3'd3, rv); chk("any_clr", 32'(rv), sb_pop());
    in2 = 5'h00;
    exp_q.push_back(32'h01); ticks(3); rd(2, 3'd3, rv); chk("any_fall", 32'(rv), sb_pop());
    exp_q.push_back(32'h1);  wr(2, 3'd2, 5'h01); chk("any_irq", 32'(irq2), sb_pop());

`ifdef PIO_CTRL_BANK_WDOG_EN
    wr(0, 3'd0, 5'h0f);
    exp_q.push_back(32'h0f); exp_q.push_back(32'h00);
    ticks(99); chk("wdog_pre_out", 32'(out0), sb_pop());
    rd(0, 3'd6, rv); chk("wdog_pre_status", 32'(rv), sb_pop());
    exp_q.push_back(32'h10); exp_q.push_back(32'h01);
    ticks(1); chk("wdog_trip_out", 32'(out0), sb_pop());
    rd(0, 3'd6, rv); chk("wdog_trip_status", 32'(rv), sb_pop());
    exp_q.push_back(32'h01); ticks(20); rd(0, 3'd6, rv); chk("wdog_sticky", 32'(rv), sb_pop());
    exp_q.push_back(32'h00); exp_q.push_back(32'h03);
    wr(0, 3'd0, 5'h03); rd(0, 3'd6, rv); chk("wdog_status_clr", 32'(rv), sb_pop());
    chk("wdog_data_wr", 32'(out0), sb_pop());
    ticks(99); wr(0, 3'd4, 5'h00);
    exp_q.push_back(32'h03); exp_q.push_back(32'h00);
    chk("wdog_expiry_wr_out", 32'(out0), sb_pop());
    rd(0, 3'd6, rv); chk("wdog_expiry_wr_status", 32'(rv), sb_pop());
    exp_q.push_back(32'h03); ticks(50); chk("wdog_restart", 32'(out0), sb_pop());
`else
    wr(0, 3'd0, 5'h0f);
    exp_q.push_back(32'h0f); exp_q.push_back(32'h00);
    ticks(150); chk("nowdog_out", 32'(out0), sb_pop());
    rd(0, 3'd6, rv); chk("nowdog_status", 32'(rv), sb_pop());
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_ctrl_bank.md
Name: pio_ctrl_bank

Overview:
Parametrised Avalon-MM slave PIO bank for the core-board Nios system. Successor to the single-register output PIOs that drive mode flags such as open-loop select and kick enables.
- Output register with atomic set/clear access.
- Synchronised input port with edge capture and a maskable interrupt.
- Zero-wait-state reads, the same as existing PIOs.

Parameters:
WIDTH, 8, width of out_port, in_port, writedata, readdata and all internal registers (1..32)
RESET_VAL, 0, value loaded into the output register on reset
SYNC_STAGES, 2, input synchroniser depth (2..4)
EDGE_MODE, 0, capture type: 0 rising, 1 falling, 2 any edge
WDOG_CYCLES, 50000, watchdog timeout in clk cycles; used only with the optional feature

Ports:
clk  in  1  system clock
reset_n  in  1  reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  WIDTH  write data
readdata  out  WIDTH  read data, combinational from address
out_port  out  WIDTH  output register to the pins
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt, active high

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All state resets asynchronously.
- Reset values:
  - data_out = RESET_VAL.
  - sync chain, in_prev, irq_mask and edge_cap = 0.
  - irq = 0.
- Write = chipselect & ~write_n. Register map:
  - addr 0 DATA rw: write loads data_out; read returns data_out.
  - addr 1 IN ro: read returns the synchronised input; writes ignored.
  - addr 2 IRQ_MASK rw.
  - addr 3 EDGE_CAP: read returns the capture bits; a write-1 clears that bit.
  - addr 4 OUTSET wo: data_out |= writedata; read returns 0.
  - addr 5 OUTCLR wo: data_out &= ~writedata; read returns 0.
  - addr 6 STATUS ro: bit0 is the watchdog trip flag; reads 0 without the optional feature.
  - addr 7 reserved: reads 0, writes ignored.
- Write latency: data_out updates on the clk edge that samples the write; out_port = data_out with no further delay.
- Read latency 0: readdata is decoded combinationally from address and registers and does not depend on chipselect.
- Input path and edge capture:
  - in_port passes through SYNC_STAGES flops to give in_sync; in_prev registers in_sync.
  - The edge term is combinational: rising = in_sync & ~in_prev; falling = ~in_sync & in_prev; any = XOR of the two.
  - edge_cap bit set on the next clk edge.
  - A change on in_port before edge k is visible in IN after edge k+SYNC_STAGES-1 and sets edge_cap at edge k+SYNC_STAGES.
- Simultaneous capture and write-1-clear on the same bit: capture wins and the bit stays 1. Other bits clear normally.
- irq = |(edge_cap & irq_mask), driven from registers with no extra delay. Deasserts the cycle after the last pending bit is cleared or masked.
- Input held high through reset: treated as a rising edge after reset release (in_prev = 0). Software clears it at init.
- Reset asserted mid-operation: all state returns to reset values immediately, and a pending irq drops asynchronously.

Optional Feature:
Macro PIO_CTRL_BANK_WDOG_EN.
- Enabled:
  - Counter width is $clog2(WDOG_CYCLES+1).
  - The counter clears on any write to addr 0, 4 or 5; otherwise it increments and saturates.
  - When it reaches WDOG_CYCLES, data_out is loaded with RESET_VAL and the sticky trip flag is set, both on the same edge.
  - The trip flag clears on the next DATA write.
  - A write on the expiry cycle takes priority: no trip, and the counter clears.
  - Motor and kick outputs fail safe if the Nios stalls.
- Disabled: no counter, STATUS reads 0, and data_out changes only through writes.

Decomposition:
- Package pio_ctrl_pkg holds:
  - address constants ADDR_DATA..ADDR_STATUS;
  - EDGE_MODE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One sub-module, pio_sync_edge: synchroniser, in_prev and edge detect, parametrised by WIDTH, SYNC_STAGES and EDGE_MODE. The top level instantiates it once.

Test Plan:
- Reset, WIDTH=5, RESET_VAL=16 -> out_port=0x10; reads of addr 0 = 0x10 and addr 3 = 0; irq=0.
- Write DATA 0x05, OUTSET 0x12, OUTCLR 0x04 -> out_port steps 0x05, 0x17, 0x13, each on the edge after its write; reads of addr 4/5 = 0.
- in_port bit2 rises, SYNC_STAGES=2, EDGE_MODE=0 -> IN bit2 set 2 edges later, edge_cap=0x04 one edge after that; mask 0x04 gives irq=1; write 0x04 to addr 3 gives irq=0 next cycle.
- Edge on bit2 on the same cycle as a write-1-clear of 0x04 -> edge_cap stays 0x04 and irq stays 1.
- EDGE_MODE=2, bit0 toggled high then low, with a clear between the two edges -> captured twice.
- With PIO_CTRL_BANK_WDOG_EN, WDOG_CYCLES=100, DATA=0x0F and no further writes:
  - after 100 cycles out_port=RESET_VAL and STATUS=1;
  - a DATA write clears STATUS;
  - a write on the expiry cycle prevents the trip.
